// File: rtl/decode_stage_pkg.sv
// Shared decode constants: opcodes, control-field codes and load/store size encodings.
// Every _X code is zero so an all-zero entry reads as "no operation".
package decode_stage_pkg;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam logic [4:0] ALU_X     = 5'd0;
    localparam logic [4:0] ALU_ADD   = 5'd1;
    localparam logic [4:0] ALU_SUB   = 5'd2;
    localparam logic [4:0] ALU_AND   = 5'd3;
    localparam logic [4:0] ALU_OR    = 5'd4;
    localparam logic [4:0] ALU_XOR   = 5'd5;
    localparam logic [4:0] ALU_SLL   = 5'd6;
    localparam logic [4:0] ALU_SRL   = 5'd7;
    localparam logic [4:0] ALU_SRA   = 5'd8;
    localparam logic [4:0] ALU_SLT   = 5'd9;
    localparam logic [4:0] ALU_SLTU  = 5'd10;
    localparam logic [4:0] BR_BEQ    = 5'd11;
    localparam logic [4:0] BR_BNE    = 5'd12;
    localparam logic [4:0] BR_BLT    = 5'd13;
    localparam logic [4:0] BR_BGE    = 5'd14;
    localparam logic [4:0] BR_BLTU   = 5'd15;
    localparam logic [4:0] BR_BGEU   = 5'd16;
    localparam logic [4:0] ALU_JALR  = 5'd17;
    // M-extension codes are contiguous in funct3 order so they can be formed by addition.
    localparam logic [4:0] ALU_MUL    = 5'd18;
    localparam logic [4:0] ALU_MULH   = 5'd19;
    localparam logic [4:0] ALU_MULHSU = 5'd20;
    localparam logic [4:0] ALU_MULHU  = 5'd21;
    localparam logic [4:0] ALU_DIV    = 5'd22;
    localparam logic [4:0] ALU_DIVU   = 5'd23;
    localparam logic [4:0] ALU_REM    = 5'd24;
    localparam logic [4:0] ALU_REMU   = 5'd25;

    localparam logic [1:0] OP1_X   = 2'd0;
    localparam logic [1:0] OP1_RS1 = 2'd1;
    localparam logic [1:0] OP1_PC  = 2'd2;

    localparam logic [2:0] OP2_X   = 3'd0;
    localparam logic [2:0] OP2_RS2 = 3'd1;
    localparam logic [2:0] OP2_IMI = 3'd2;
    localparam logic [2:0] OP2_IMS = 3'd3;
    localparam logic [2:0] OP2_IMJ = 3'd4;
    localparam logic [2:0] OP2_IMU = 3'd5;

    localparam logic [1:0] MEN_X = 2'd0;
    localparam logic [1:0] MEN_S = 2'd1;

    localparam logic [1:0] REN_X = 2'd0;
    localparam logic [1:0] REN_S = 2'd1;

    localparam logic [2:0] WB_X   = 3'd0;
    localparam logic [2:0] WB_ALU = 3'd1;
    localparam logic [2:0] WB_MEM = 3'd2;
    localparam logic [2:0] WB_PC  = 3'd3;

    localparam logic [2:0] MEM_B  = 3'b000;
    localparam logic [2:0] MEM_H  = 3'b001;
    localparam logic [2:0] MEM_W  = 3'b010;
    localparam logic [2:0] MEM_BU = 3'b100;
    localparam logic [2:0] MEM_HU = 3'b101;

    function automatic logic legal_load_size(input logic [2:0] funct3);
        return (funct3 == MEM_B) || (funct3 == MEM_H) || (funct3 == MEM_W) ||
               (funct3 == MEM_BU) || (funct3 == MEM_HU);
    endfunction

    function automatic logic legal_store_size(input logic [2:0] funct3);
        return (funct3 == MEM_B) || (funct3 == MEM_H) || (funct3 == MEM_W);
    endfunction

endpackage

// File: rtl/decode_stage_logic.sv
// Combinational instruction decoder (module decode_logic).
// Define DECODE_MEXT_EN to decode RV32M; otherwise those encodings are flagged illegal.
module decode_logic
    import decode_stage_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     inst,
    output logic [XLEN-1:0] imm,
    output logic [4:0]      op1_addr,
    output logic [4:0]      op2_addr,
    output logic [4:0]      rd_addr,
    output logic [4:0]      exe_fun,
    output logic [1:0]      op1,
    output logic [2:0]      op2,
    output logic [1:0]      mem_wen,
    output logic [1:0]      rf_wen,
    output logic [2:0]      wb_sel,
    output logic [2:0]      mem_size,
    output logic            illegal
);

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic        legal_f7;
    logic [31:0] imm_i, imm_s, imm_b, imm_j, imm_u;

    assign opcode   = inst[6:0];
    assign funct3   = inst[14:12];
    assign funct7   = inst[31:25];
    assign op1_addr = inst[19:15];
    assign op2_addr = inst[24:20];
    assign rd_addr  = inst[11:7];
    assign legal_f7 = (funct7 == 7'b0000000) || (funct7 == 7'b0100000);

    assign imm_i = {{20{inst[31]}}, inst[31:20]};
    assign imm_s = {{20{inst[31]}}, inst[31:25], inst[11:7]};
    assign imm_b = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
    assign imm_j = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
    assign imm_u = {inst[31:12], 12'b0};

    // Decode each opcode, then collapse anything flagged illegal to the _X codes.
    always_comb begin
        imm      = '0;
        exe_fun  = ALU_X;
        op1      = OP1_X;
        op2      = OP2_X;
        mem_wen  = MEN_X;
        rf_wen   = REN_X;
        wb_sel   = WB_X;
        mem_size = '0;
        illegal  = 1'b0;
        case (opcode)
            OPC_LUI: begin
                imm = XLEN'($signed(imm_u));
                exe_fun = ALU_ADD; op2 = OP2_IMU; rf_wen = REN_S; wb_sel = WB_ALU;
            end
            OPC_AUIPC: begin
                imm = XLEN'($signed(imm_u));
                exe_fun = ALU_ADD; op1 = OP1_PC; op2 = OP2_IMU; rf_wen = REN_S; wb_sel = WB_ALU;
            end
            OPC_JAL: begin
                imm = XLEN'($signed(imm_j));
                exe_fun = ALU_ADD; op1 = OP1_PC; op2 = OP2_IMJ; rf_wen = REN_S; wb_sel = WB_PC;
            end
            OPC_JALR: begin
                imm = XLEN'($signed(imm_i));
                exe_fun = ALU_JALR; op1 = OP1_RS1; op2 = OP2_IMI; rf_wen = REN_S; wb_sel = WB_PC;
            end
            OPC_BRANCH: begin
                imm = XLEN'($signed(imm_b));
                op1 = OP1_RS1; op2 = OP2_RS2;
                case (funct3)
                    3'b000:  exe_fun = BR_BEQ;
                    3'b001:  exe_fun = BR_BNE;
                    3'b100:  exe_fun = BR_BLT;
                    3'b101:  exe_fun = BR_BGE;
                    3'b110:  exe_fun = BR_BLTU;
                    3'b111:  exe_fun = BR_BGEU;
                    default: illegal = 1'b1;
                endcase
            end
            OPC_LOAD: begin
                imm = XLEN'($signed(imm_i));
                exe_fun = ALU_ADD; op1 = OP1_RS1; op2 = OP2_IMI; rf_wen = REN_S; wb_sel = WB_MEM;
                mem_size = funct3;
                illegal = !legal_load_size(funct3);
            end
            OPC_STORE: begin
                imm = XLEN'($signed(imm_s));
                exe_fun = ALU_ADD; op1 = OP1_RS1; op2 = OP2_IMS; mem_wen = MEN_S;
                mem_size = funct3;
                illegal = !legal_store_size(funct3);
            end
            OPC_OPIMM: begin
                imm = XLEN'($signed(imm_i));
                op1 = OP1_RS1; op2 = OP2_IMI; rf_wen = REN_S; wb_sel = WB_ALU;
                case (funct3)
                    3'b000: exe_fun = ALU_ADD;
                    3'b010: exe_fun = ALU_SLT;
                    3'b011: exe_fun = ALU_SLTU;
                    3'b100: exe_fun = ALU_XOR;
                    3'b110: exe_fun = ALU_OR;
                    3'b111: exe_fun = ALU_AND;
                    3'b001: begin
                        imm = XLEN'(inst[24:20]);
                        exe_fun = ALU_SLL;
                        illegal = !legal_f7;
                    end
                    default: begin
                        imm = XLEN'(inst[24:20]);
                        exe_fun = inst[30] ? ALU_SRA : ALU_SRL;
                        illegal = !legal_f7;
                    end
                endcase
            end
            OPC_OP: begin
                op1 = OP1_RS1; op2 = OP2_RS2; rf_wen = REN_S; wb_sel = WB_ALU;
                if (funct7 == 7'b0000001) begin
`ifdef DECODE_MEXT_EN
                    exe_fun = ALU_MUL + {2'b00, funct3};
`else
                    illegal = 1'b1;
`endif
                end else if (!legal_f7) begin
                    illegal = 1'b1;
                end else begin
                    case (funct3)
                        3'b000:  exe_fun = inst[30] ? ALU_SUB : ALU_ADD;
                        3'b001:  exe_fun = ALU_SLL;
                        3'b010:  exe_fun = ALU_SLT;
                        3'b011:  exe_fun = ALU_SLTU;
                        3'b100:  exe_fun = ALU_XOR;
                        3'b101:  exe_fun = inst[30] ? ALU_SRA : ALU_SRL;
                        3'b110:  exe_fun = ALU_OR;
                        default: exe_fun = ALU_AND;
                    endcase
                end
            end
            default: illegal = 1'b1;
        endcase
        if (illegal) begin
            imm      = '0;
            exe_fun  = ALU_X;
            op1      = OP1_X;
            op2      = OP2_X;
            mem_wen  = MEN_X;
            rf_wen   = REN_X;
            wb_sel   = WB_X;
            mem_size = '0;
        end
    end

endmodule

// File: rtl/decode_stage.sv
// Registered decode stage: decode_logic feeding a DEPTH-entry FIFO toward execute.
// DECODE_MEXT_EN (see decode_logic) enables RV32M decoding.
module decode_stage
    import decode_stage_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     inst,
    input  logic [XLEN-1:0] pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] imm,
    output logic [4:0]      op1_addr,
    output logic [4:0]      op2_addr,
    output logic [4:0]      rd_addr,
    output logic [4:0]      exe_fun,
    output logic [1:0]      op1,
    output logic [2:0]      op2,
    output logic [1:0]      mem_wen,
    output logic [1:0]      rf_wen,
    output logic [2:0]      wb_sel,
    output logic [2:0]      mem_size,
    output logic            illegal
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] imm;
        logic [4:0]      op1_addr;
        logic [4:0]      op2_addr;
        logic [4:0]      rd_addr;
        logic [4:0]      exe_fun;
        logic [1:0]      op1;
        logic [2:0]      op2;
        logic [1:0]      mem_wen;
        logic [1:0]      rf_wen;
        logic [2:0]      wb_sel;
        logic [2:0]      mem_size;
        logic            illegal;
    } entry_t;

    localparam entry_t EMPTY_ENTRY = '{
        pc: '0, imm: '0, op1_addr: '0, op2_addr: '0, rd_addr: '0,
        exe_fun: ALU_X, op1: OP1_X, op2: OP2_X, mem_wen: MEN_X,
        rf_wen: REN_X, wb_sel: WB_X, mem_size: '0, illegal: 1'b0
    };

    entry_t          buffer [DEPTH];
    entry_t          dec_entry;
    entry_t          head;
    logic [PW-1:0]   wr_ptr, rd_ptr;
    logic [CW-1:0]   count;
    logic            push, pop;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign dec_entry.pc = pc;

    decode_logic #(.XLEN(XLEN)) u_decode (
        .inst     (inst),
        .imm      (dec_entry.imm),
        .op1_addr (dec_entry.op1_addr),
        .op2_addr (dec_entry.op2_addr),
        .rd_addr  (dec_entry.rd_addr),
        .exe_fun  (dec_entry.exe_fun),
        .op1      (dec_entry.op1),
        .op2      (dec_entry.op2),
        .mem_wen  (dec_entry.mem_wen),
        .rf_wen   (dec_entry.rf_wen),
        .wb_sel   (dec_entry.wb_sel),
        .mem_size (dec_entry.mem_size),
        .illegal  (dec_entry.illegal)
    );

    // Ready depends only on the registered count, so execute stalls never reach fetch combinationally.
    assign in_ready  = (count != CW'(DEPTH));
    assign out_valid = (count != '0);
    assign push      = in_valid && in_ready && !flush;
    assign pop       = out_valid && out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                buffer[i] <= EMPTY_ENTRY;
            end
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                buffer[wr_ptr] <= dec_entry;
                wr_ptr         <= next_ptr(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
        end
    end

    assign head     = buffer[rd_ptr];
    assign out_pc   = head.pc;
    assign imm      = head.imm;
    assign op1_addr = head.op1_addr;
    assign op2_addr = head.op2_addr;
    assign rd_addr  = head.rd_addr;
    assign exe_fun  = head.exe_fun;
    assign op1      = head.op1;
    assign op2      = head.op2;
    assign mem_wen  = head.mem_wen;
    assign rf_wen   = head.rf_wen;
    assign wb_sel   = head.wb_sel;
    assign mem_size = head.mem_size;
    assign illegal  = head.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: decode vector table plus buffer/flush/reset sequences.
module tb_decode_stage;
    import decode_stage_pkg::*;

    typedef struct {
        string       name;
        logic [31:0] inst;
        logic [31:0] imm;
        logic [4:0]  exe_fun;
        logic [1:0]  op1;
        logic [2:0]  op2;
        logic [1:0]  mem_wen;
        logic [1:0]  rf_wen;
        logic [2:0]  wb_sel;
        logic [2:0]  mem_size;
        logic        illegal;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] inst = '0;
    logic [31:0] pc = '0;
    logic [63:0] pc64 = '0;

    logic        in_ready, out_valid, illegal;
    logic [31:0] out_pc, imm;
    logic [4:0]  op1_addr, op2_addr, rd_addr, exe_fun;
    logic [1:0]  op1, mem_wen, rf_wen;
    logic [2:0]  op2, wb_sel, mem_size;

    logic        in_ready64, out_valid64, illegal64;
    logic [63:0] out_pc64, imm64;
    logic [4:0]  op1_addr64, op2_addr64, rd_addr64, exe_fun64;
    logic [1:0]  op1_64, mem_wen64, rf_wen64;
    logic [2:0]  op2_64, wb_sel64, mem_size64;

    int tests_run = 0;
    int tests_failed = 0;
    vec_t vecs[$];

    always #5 clk = ~clk;

    decode_stage #(.XLEN(32), .DEPTH(2)) dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .inst(inst), .pc(pc), .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .imm(imm), .op1_addr(op1_addr), .op2_addr(op2_addr), .rd_addr(rd_addr),
        .exe_fun(exe_fun), .op1(op1), .op2(op2), .mem_wen(mem_wen), .rf_wen(rf_wen),
        .wb_sel(wb_sel), .mem_size(mem_size), .illegal(illegal)
    );

    decode_stage #(.XLEN(64), .DEPTH(2)) dut64 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready64),
        .inst(inst), .pc(pc64), .out_valid(out_valid64), .out_ready(out_ready), .out_pc(out_pc64),
        .imm(imm64), .op1_addr(op1_addr64), .op2_addr(op2_addr64), .rd_addr(rd_addr64),
        .exe_fun(exe_fun64), .op1(op1_64), .op2(op2_64), .mem_wen(mem_wen64), .rf_wen(rf_wen64),
        .wb_sel(wb_sel64), .mem_size(mem_size64), .illegal(illegal64)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [31:0] i_inst, input logic [31:0] i_pc, input logic i_valid);
        inst     = i_inst;
        pc       = i_pc;
        pc64     = {32'h0, i_pc};
        in_valid = i_valid;
    endtask

    task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    function automatic vec_t mk(input string n, input logic [31:0] i, input logic [31:0] im,
                                input logic [4:0] ef, input logic [1:0] o1, input logic [2:0] o2,
                                input logic [1:0] mw, input logic [1:0] rw, input logic [2:0] wb,
                                input logic [2:0] ms, input logic il);
        vec_t v;
        v.name = n; v.inst = i; v.imm = im; v.exe_fun = ef; v.op1 = o1; v.op2 = o2;
        v.mem_wen = mw; v.rf_wen = rw; v.wb_sel = wb; v.mem_size = ms; v.illegal = il;
        return v;
    endfunction

    function automatic vec_t mk_illegal(input string n, input logic [31:0] i);
        return mk(n, i, 32'h0, ALU_X, OP1_X, OP2_X, MEN_X, REN_X, WB_X, 3'b000, 1'b1);
    endfunction

    initial begin
        vecs.push_back(mk("addi", 32'hFFF10093, 32'hFFFFFFFF, ALU_ADD, OP1_RS1, OP2_IMI, MEN_X, REN_S, WB_ALU, 3'b000, 1'b0));
        vecs.push_back(mk("lui", 32'h123452B7, 32'h12345000, ALU_ADD, OP1_X, OP2_IMU, MEN_X, REN_S, WB_ALU, 3'b000, 1'b0));
        vecs.push_back(mk("auipc", 32'h00001097, 32'h00001000, ALU_ADD, OP1_PC, OP2_IMU, MEN_X, REN_S, WB_ALU, 3'b000, 1'b0));
        vecs.push_back(mk("jal", 32'hFFDFF0EF, 32'hFFFFFFFC, ALU_ADD, OP1_PC, OP2_IMJ, MEN_X, REN_S, WB_PC, 3'b000, 1'b0));
        vecs.push_back(mk("jalr", 32'h00008067, 32'h00000000, ALU_JALR, OP1_RS1, OP2_IMI, MEN_X, REN_S, WB_PC, 3'b000, 1'b0));
        vecs.push_back(mk("beq", 32'h00208463, 32'h00000008, BR_BEQ, OP1_RS1, OP2_RS2, MEN_X, REN_X, WB_X, 3'b000, 1'b0));
        vecs.push_back(mk("bne", 32'hFE209EE3, 32'hFFFFFFFC, BR_BNE, OP1_RS1, OP2_RS2, MEN_X, REN_X, WB_X, 3'b000, 1'b0));
        vecs.push_back(mk("lw", 32'h0040A183, 32'h00000004, ALU_ADD, OP1_RS1, OP2_IMI, MEN_X, REN_S, WB_MEM, 3'b010, 1'b0));
        vecs.push_back(mk("lbu", 32'hFFF0C183, 32'hFFFFFFFF, ALU_ADD, OP1_RS1, OP2_IMI, MEN_X, REN_S, WB_MEM, 3'b100, 1'b0));
        vecs.push_back(mk("sh", 32'hFE209F23, 32'hFFFFFFFE, ALU_ADD, OP1_RS1, OP2_IMS, MEN_S, REN_X, WB_X, 3'b001, 1'b0));
        vecs.push_back(mk("srai", 32'h40315093, 32'h00000003, ALU_SRA, OP1_RS1, OP2_IMI, MEN_X, REN_S, WB_ALU, 3'b000, 1'b0));
        vecs.push_back(mk("sub", 32'h402081B3, 32'h00000000, ALU_SUB, OP1_RS1, OP2_RS2, MEN_X, REN_S, WB_ALU, 3'b000, 1'b0));
        vecs.push_back(mk("add_x0", 32'h00208033, 32'h00000000, ALU_ADD, OP1_RS1, OP2_RS2, MEN_X, REN_S, WB_ALU, 3'b000, 1'b0));
        vecs.push_back(mk_illegal("zero_inst", 32'h00000000));
        vecs.push_back(mk_illegal("load_f3_011", 32'h0040B183));
        vecs.push_back(mk_illegal("store_f3_011", 32'h0020B023));
        vecs.push_back(mk_illegal("branch_f3_010", 32'h0020A463));
        vecs.push_back(mk_illegal("op_bad_f7", 32'h042081B3));
`ifdef DECODE_MEXT_EN
        vecs.push_back(mk("mul", 32'h022081B3, 32'h00000000, ALU_MUL, OP1_RS1, OP2_RS2, MEN_X, REN_S, WB_ALU, 3'b000, 1'b0));
`else
        vecs.push_back(mk_illegal("mul", 32'h022081B3));
`endif

        // Reset state
        step();
        checkOutput("rst_in_ready", in_ready, 1);
        checkOutput("rst_out_valid", out_valid, 0);
        checkOutput("rst_out_pc", out_pc, 0);
        checkOutput("rst_imm", imm, 0);
        checkOutput("rst_exe_fun", exe_fun, ALU_X);
        checkOutput("rst_wb_sel", wb_sel, WB_X);
        checkOutput("rst_illegal", illegal, 0);
        rst = 1'b0;
        step();

        // Decode table: push one, check it next cycle, then let it pop
        out_ready = 1'b1;
        foreach (vecs[k]) begin
            vec_t v;
            logic [31:0] vi;
            logic [31:0] vpc;
            v   = vecs[k];
            vi  = v.inst;
            vpc = 32'h1000 + 32'(k) * 4;
            applyStimulus(vi, vpc, 1'b1);
            step();
            applyStimulus(32'h0, 32'h0, 1'b0);
            checkOutput({v.name, "_valid"}, out_valid, 1);
            checkOutput({v.name, "_pc"}, out_pc, vpc);
            checkOutput({v.name, "_imm"}, imm, v.imm);
            checkOutput({v.name, "_exe_fun"}, exe_fun, v.exe_fun);
            checkOutput({v.name, "_op1"}, op1, v.op1);
            checkOutput({v.name, "_op2"}, op2, v.op2);
            checkOutput({v.name, "_mem_wen"}, mem_wen, v.mem_wen);
            checkOutput({v.name, "_rf_wen"}, rf_wen, v.rf_wen);
            checkOutput({v.name, "_wb_sel"}, wb_sel, v.wb_sel);
            checkOutput({v.name, "_mem_size"}, mem_size, v.mem_size);
            checkOutput({v.name, "_illegal"}, illegal, v.illegal);
            checkOutput({v.name, "_rd"}, rd_addr, vi[11:7]);
            checkOutput({v.name, "_rs1"}, op1_addr, vi[19:15]);
            checkOutput({v.name, "_rs2"}, op2_addr, vi[24:20]);
            step();
            checkOutput({v.name, "_popped"}, out_valid, 0);
        end

        // Sign extension of U immediate on both widths
        applyStimulus(32'h800002B7, 32'h2000, 1'b1);
        step();
        applyStimulus(32'h0, 32'h0, 1'b0);
        checkOutput("lui32_imm", imm, 64'h0000_0000_8000_0000);
        checkOutput("lui64_imm", imm64, 64'hFFFF_FFFF_8000_0000);
        checkOutput("lui64_pc", out_pc64, 64'h2000);
        step();

        // Back-to-back throughput with out_ready held high
        for (int n = 0; n < 3; n++) begin
            applyStimulus(32'hFFF10093, 32'h200 + 32'(n) * 4, 1'b1);
            step();
            checkOutput("thru_valid", out_valid, 1);
            checkOutput("thru_in_ready", in_ready, 1);
            checkOutput("thru_pc", out_pc, 32'h200 + 32'(n) * 4);
        end
        applyStimulus(32'h0, 32'h0, 1'b0);
        step();
        checkOutput("thru_drained", out_valid, 0);

        // Backpressure: fill DEPTH=2, third offer stalls, order preserved
        out_ready = 1'b0;
        applyStimulus(32'h00208033, 32'h300, 1'b1);
        step();
        applyStimulus(32'h402081B3, 32'h304, 1'b1);
        step();
        applyStimulus(32'h0040A183, 32'h308, 1'b1);
        checkOutput("bp_full_in_ready", in_ready, 0);
        checkOutput("bp_full_pc", out_pc, 32'h300);
        step();
        checkOutput("bp_hold_pc", out_pc, 32'h300);
        checkOutput("bp_hold_exe", exe_fun, ALU_ADD);
        checkOutput("bp_hold_in_ready", in_ready, 0);
        out_ready = 1'b1;
        step();
        checkOutput("bp_pop1_in_ready", in_ready, 1);
        checkOutput("bp_pop1_pc", out_pc, 32'h304);
        checkOutput("bp_pop1_exe", exe_fun, ALU_SUB);
        step();
        applyStimulus(32'h0, 32'h0, 1'b0);
        checkOutput("bp_third_pc", out_pc, 32'h308);
        checkOutput("bp_third_wb", wb_sel, WB_MEM);
        checkOutput("bp_third_valid", out_valid, 1);
        step();
        checkOutput("bp_drained", out_valid, 0);

        // Flush with a full buffer and a same-cycle offer
        out_ready = 1'b0;
        applyStimulus(32'h00208033, 32'h400, 1'b1);
        step();
        applyStimulus(32'h00208033, 32'h404, 1'b1);
        step();
        checkOutput("fl_pre_valid", out_valid, 1);
        applyStimulus(32'h00208033, 32'h408, 1'b1);
        flush = 1'b1;
        step();
        flush = 1'b0;
        applyStimulus(32'h0, 32'h0, 1'b0);
        checkOutput("fl_out_valid", out_valid, 0);
        checkOutput("fl_in_ready", in_ready, 1);
        out_ready = 1'b1;
        step();
        checkOutput("fl_nothing_delivered", out_valid, 0);

        // Asynchronous reset mid-operation drops the held entry at once
        out_ready = 1'b0;
        applyStimulus(32'h00208033, 32'h500, 1'b1);
        step();
        applyStimulus(32'h0, 32'h0, 1'b0);
        checkOutput("mr_pre_valid", out_valid, 1);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("mr_out_valid", out_valid, 0);
        checkOutput("mr_out_pc", out_pc, 0);
        checkOutput("mr_in_ready", in_ready, 1);
        step();
        rst = 1'b0;
        step();
        checkOutput("mr_after_valid", out_valid, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
